// File: rtl/wam_round_controller.sv
// Whack-a-mole round sequencer: gap/on timing, LFSR mole pick, hit judging, score/miss/round counts.
// Optional WAM_DEATHMATCH_EN adds a latched deathmatch input: a timeout or wrong hit ends the game.
module wam_round_controller #(
    parameter int unsigned NUM_MOLES = 9,
    parameter int unsigned TIMER_W   = 28,
    parameter int unsigned CNT_W     = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [7:0]           seed,
`ifdef WAM_DEATHMATCH_EN
    input  logic                 deathmatch,
`endif
    input  logic [TIMER_W-1:0]   time_between,
    input  logic [TIMER_W-1:0]   time_on,
    input  logic [CNT_W-1:0]     total_points,
    input  logic                 hit_valid,
    input  logic [3:0]           hit_idx,
    output logic [NUM_MOLES-1:0] lights,
    output logic [CNT_W-1:0]     score,
    output logic [CNT_W-1:0]     misses,
    output logic [CNT_W-1:0]     round_cnt,
    output logic                 hit_pulse,
    output logic                 miss_pulse,
    output logic                 game_over
);

    localparam logic [7:0] LFSR_INIT = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;  // x^8+x^6+x^5+x^4+1, right-shift Galois form

    typedef enum logic [1:0] {
        S_IDLE,
        S_GAP,
        S_ON,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [TIMER_W-1:0]   tb_q, tb_d;
    logic [TIMER_W-1:0]   ton_q, ton_d;
    logic [CNT_W-1:0]     tp_q, tp_d;
    logic                 dm_q, dm_d;
    logic [7:0]           lfsr_q, lfsr_d;
    logic [3:0]           idx_q, idx_d;
    logic [3:0]           prev_q, prev_d;
    logic [NUM_MOLES-1:0] lights_d;
    logic [CNT_W-1:0]     score_d, misses_d, round_d;
    logic                 hit_pulse_d, miss_pulse_d, game_over_d;

    logic [7:0]           lfsr_step;
    logic [3:0]           raw_idx, wrap_idx, pick_idx;
    logic                 hit_ok, timeout, wrong_end, round_end;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Mole selection from the stepped LFSR, folded into range and never repeating the previous mole
    always_comb begin
        lfsr_step = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 8'h00);
        raw_idx   = lfsr_step[3:0];
        wrap_idx  = (raw_idx >= 4'(NUM_MOLES)) ? raw_idx - 4'(NUM_MOLES) : raw_idx;
        if (wrap_idx == prev_q)
            pick_idx = (wrap_idx == 4'(NUM_MOLES - 1)) ? 4'd0 : wrap_idx + 4'd1;
        else
            pick_idx = wrap_idx;
    end

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        tb_d         = tb_q;
        ton_d        = ton_q;
        tp_d         = tp_q;
        dm_d         = dm_q;
        lfsr_d       = lfsr_q;
        idx_d        = idx_q;
        prev_d       = prev_q;
        lights_d     = lights;
        score_d      = score;
        misses_d     = misses;
        round_d      = round_cnt;
        hit_pulse_d  = 1'b0;
        miss_pulse_d = 1'b0;
        hit_ok       = hit_valid && (hit_idx == idx_q);
        timeout      = (timer_q == ton_q);
        wrong_end    = hit_valid && !hit_ok && dm_q;
        round_end    = 1'b0;

        case (state_q)
            S_GAP: begin
                if (timer_q == tb_q) begin
                    state_d  = S_ON;
                    timer_d  = '0;
                    lfsr_d   = lfsr_step;
                    idx_d    = pick_idx;
                    prev_d   = pick_idx;
                    lights_d = NUM_MOLES'(1) << pick_idx;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            S_ON: begin
                // A correct hit wins over a timeout in the same cycle
                if (hit_ok) begin
                    score_d     = sat_inc(score);
                    hit_pulse_d = 1'b1;
                    round_end   = 1'b1;
                end else if (timeout || wrong_end) begin
                    misses_d     = sat_inc(misses);
                    miss_pulse_d = 1'b1;
                    round_end    = 1'b1;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
                if (round_end) begin
                    round_d  = sat_inc(round_cnt);
                    lights_d = '0;
                    timer_d  = '0;
                    state_d  = (round_d == tp_q || (dm_q && !hit_ok)) ? S_DONE : S_GAP;
                end
            end
            default: ;
        endcase

        if (start) begin
            tb_d         = time_between;
            ton_d        = time_on;
            tp_d         = total_points;
`ifdef WAM_DEATHMATCH_EN
            dm_d         = deathmatch;
`else
            dm_d         = 1'b0;
`endif
            lfsr_d       = (seed == 8'h00) ? LFSR_INIT : seed;
            timer_d      = '0;
            score_d      = '0;
            misses_d     = '0;
            round_d      = '0;
            lights_d     = '0;
            hit_pulse_d  = 1'b0;
            miss_pulse_d = 1'b0;
            state_d      = (total_points == '0) ? S_DONE : S_GAP;
        end

        game_over_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            tb_q       <= '0;
            ton_q      <= '0;
            tp_q       <= '0;
            dm_q       <= 1'b0;
            lfsr_q     <= LFSR_INIT;
            idx_q      <= '0;
            prev_q     <= '0;
            lights     <= '0;
            score      <= '0;
            misses     <= '0;
            round_cnt  <= '0;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            tb_q       <= tb_d;
            ton_q      <= ton_d;
            tp_q       <= tp_d;
            dm_q       <= dm_d;
            lfsr_q     <= lfsr_d;
            idx_q      <= idx_d;
            prev_q     <= prev_d;
            lights     <= lights_d;
            score      <= score_d;
            misses     <= misses_d;
            round_cnt  <= round_d;
            hit_pulse  <= hit_pulse_d;
            miss_pulse <= miss_pulse_d;
            game_over  <= game_over_d;
        end
    end

endmodule

// File: tb/tb_wam_round_controller.sv
// Directed testbench for wam_round_controller; define WAM_DEATHMATCH_EN to also exercise deathmatch.
module tb_wam_round_controller;

    localparam int unsigned NM = 9;
    localparam int unsigned TW = 28;
    localparam int unsigned CW = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    seed = 8'h00;
`ifdef WAM_DEATHMATCH_EN
    logic          deathmatch = 1'b0;
`endif
    logic [TW-1:0] time_between = '0;
    logic [TW-1:0] time_on = '0;
    logic [CW-1:0] total_points = '0;
    logic          hit_valid = 1'b0;
    logic [3:0]    hit_idx = '0;
    logic [NM-1:0] lights;
    logic [CW-1:0] score, misses, round_cnt;
    logic          hit_pulse, miss_pulse, game_over;

    int checks = 0;
    int errors = 0;

    wam_round_controller dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .seed         (seed),
`ifdef WAM_DEATHMATCH_EN
        .deathmatch   (deathmatch),
`endif
        .time_between (time_between),
        .time_on      (time_on),
        .total_points (total_points),
        .hit_valid    (hit_valid),
        .hit_idx      (hit_idx),
        .lights       (lights),
        .score        (score),
        .misses       (misses),
        .round_cnt    (round_cnt),
        .hit_pulse    (hit_pulse),
        .miss_pulse   (miss_pulse),
        .game_over    (game_over)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic do_start(input logic [7:0] s, input int tb, input int ton, input int tp);
        seed         = s;
        time_between = TW'(tb);
        time_on      = TW'(ton);
        total_points = CW'(tp);
        start        = 1'b1;
        tick();
        start        = 1'b0;
    endtask

    // Bounded wait for a lit mole; reports whether it appeared
    task automatic wait_lit(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (lights != '0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_dark(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (lights == '0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    function automatic int onehot_idx(input logic [NM-1:0] v);
        int r = -1;
        for (int i = 0; i < int'(NM); i++)
            if (v[i]) r = i;
        return r;
    endfunction

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if ({lights, score, misses, round_cnt, hit_pulse, miss_pulse, game_over} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: lights=%h score=%0d misses=%0d round=%0d go=%b, required all zero",
                     lights, score, misses, round_cnt, game_over);
        end
    endtask

    task automatic test_timeout_rounds();
        int first_on = -1, on_cnt = 0, mp = 0, miss_t = -1;
        logic [NM-1:0] m1 = '0, m2 = '0;
        do_reset();
        do_start(8'hA5, 3, 5, 2);
        for (int t = 1; t <= 25; t++) begin
            tick();
            if (lights != '0) begin
                on_cnt++;
                if (first_on < 0) first_on = t;
            end
            if (t == 4) m1 = lights;
            if (t == 14) m2 = lights;
            if (miss_pulse) begin
                mp++;
                if (miss_t < 0) miss_t = t;
            end
        end
        checks++;
        if (first_on !== 4) begin
            errors++;
            $display("FAIL first_on_cycle: got %0d, required 4", first_on);
        end
        checks++;
        if (on_cnt !== 12) begin
            errors++;
            $display("FAIL on_window_cycles: got %0d, required 12", on_cnt);
        end
        checks++;
        if (miss_t !== 10 || mp !== 2) begin
            errors++;
            $display("FAIL miss_pulses: first at %0d count %0d, required 10 and 2", miss_t, mp);
        end
        checks++;
        if (m1 !== 9'h002 || m2 !== 9'h020) begin
            errors++;
            $display("FAIL mole_sequence: got %h %h, required 002 020", m1, m2);
        end
        checks++;
        if (misses !== 6'd2 || round_cnt !== 6'd2 || score !== 6'd0 || game_over !== 1'b1) begin
            errors++;
            $display("FAIL timeout_end: misses=%0d round=%0d score=%0d go=%b, required 2 2 0 1",
                     misses, round_cnt, score, game_over);
        end
    endtask

    task automatic test_hits();
        bit ok;
        logic [NM-1:0] exp_m [2];
        exp_m[0] = 9'h002;
        exp_m[1] = 9'h020;
        do_reset();
        do_start(8'hA5, 3, 5, 2);
        for (int r = 0; r < 2; r++) begin
            wait_lit(ok);
            checks++;
            if (!ok || lights !== exp_m[r]) begin
                errors++;
                $display("FAIL hit_round%0d_mole: got %h, required %h", r, lights, exp_m[r]);
            end
            tick();
            hit_valid = 1'b1;
            hit_idx   = 4'(onehot_idx(exp_m[r]));
            tick();
            hit_valid = 1'b0;
            checks++;
            if (hit_pulse !== 1'b1 || miss_pulse !== 1'b0 || lights !== '0) begin
                errors++;
                $display("FAIL hit_round%0d_pulse: hp=%b mp=%b lights=%h, required 1 0 000",
                         r, hit_pulse, miss_pulse, lights);
            end
        end
        checks++;
        if (score !== 6'd2 || misses !== 6'd0 || round_cnt !== 6'd2 || game_over !== 1'b1) begin
            errors++;
            $display("FAIL hits_end: score=%0d misses=%0d round=%0d go=%b, required 2 0 2 1",
                     score, misses, round_cnt, game_over);
        end
    endtask

    task automatic test_hit_on_timeout_and_wrong();
        bit ok;
        do_reset();
        do_start(8'hA5, 1, 3, 1);
        wait_lit(ok);
        hit_valid = 1'b1;
        hit_idx   = 4'd4;
        tick();
        hit_valid = 1'b0;
        checks++;
        if (!ok || lights !== 9'h002 || score !== 6'd0 || misses !== 6'd0 || hit_pulse !== 1'b0) begin
            errors++;
            $display("FAIL wrong_hit_ignored: lights=%h score=%0d misses=%0d hp=%b, required 002 0 0 0",
                     lights, score, misses, hit_pulse);
        end
        tick();
        tick();
        hit_valid = 1'b1;
        hit_idx   = 4'd1;
        tick();
        hit_valid = 1'b0;
        checks++;
        if (score !== 6'd1 || misses !== 6'd0 || miss_pulse !== 1'b0 || hit_pulse !== 1'b1 ||
            game_over !== 1'b1) begin
            errors++;
            $display("FAIL hit_on_timeout: score=%0d misses=%0d mp=%b hp=%b go=%b, required 1 0 0 1 1",
                     score, misses, miss_pulse, hit_pulse, game_over);
        end
    endtask

    task automatic test_restart();
        bit ok;
        do_reset();
        do_start(8'hA5, 2, 10, 3);
        wait_lit(ok);
        hit_valid = 1'b1;
        hit_idx   = 4'd1;
        tick();
        hit_valid = 1'b0;
        wait_lit(ok);
        tick();
        tick();
        do_start(8'hA5, 2, 10, 3);
        checks++;
        if (lights !== '0 || score !== '0 || misses !== '0 || round_cnt !== '0 || game_over !== 1'b0) begin
            errors++;
            $display("FAIL restart_clear: lights=%h score=%0d misses=%0d round=%0d go=%b, required all 0",
                     lights, score, misses, round_cnt, game_over);
        end
        tick();
        tick();
        checks++;
        if (lights !== '0) begin
            errors++;
            $display("FAIL restart_gap: lights=%h, required 000", lights);
        end
        tick();
        checks++;
        if (lights !== 9'h002) begin
            errors++;
            $display("FAIL restart_first_mole: lights=%h, required 002", lights);
        end
    endtask

    task automatic test_zero_points_and_seed0();
        do_reset();
        do_start(8'h11, 3, 3, 0);
        checks++;
        if (game_over !== 1'b1 || lights !== '0 || round_cnt !== '0) begin
            errors++;
            $display("FAIL zero_points: go=%b lights=%h round=%0d, required 1 000 0",
                     game_over, lights, round_cnt);
        end
        tick();
        tick();
        checks++;
        if (game_over !== 1'b1) begin
            errors++;
            $display("FAIL done_hold: go=%b, required 1", game_over);
        end
        do_reset();
        do_start(8'h00, 0, 0, 1);
        tick();
        checks++;
        if (lights !== 9'h002) begin
            errors++;
            $display("FAIL seed_zero_mole: lights=%h, required 002", lights);
        end
        tick();
        checks++;
        if (miss_pulse !== 1'b1 || misses !== 6'd1 || game_over !== 1'b1) begin
            errors++;
            $display("FAIL zero_on_window: mp=%b misses=%0d go=%b, required 1 1 1",
                     miss_pulse, misses, game_over);
        end
    endtask

    task automatic test_long_run();
        bit ok;
        int prev = -1, cur, bad = 0, seen = 0;
        do_reset();
        do_start(8'h3C, 0, 1, 50);
        for (int r = 0; r < 50; r++) begin
            wait_lit(ok);
            if (!ok) break;
            seen++;
            cur = onehot_idx(lights);
            if (!$onehot(lights) || cur < 0 || cur >= int'(NM) || cur == prev) bad++;
            prev = cur;
            wait_dark(ok);
            if (!ok) break;
        end
        checks++;
        if (seen !== 50 || bad !== 0) begin
            errors++;
            $display("FAIL long_run_moles: rounds=%0d bad=%0d, required 50 0", seen, bad);
        end
        checks++;
        if (round_cnt !== 6'd50 || misses !== 6'd50 || game_over !== 1'b1) begin
            errors++;
            $display("FAIL long_run_end: round=%0d misses=%0d go=%b, required 50 50 1",
                     round_cnt, misses, game_over);
        end
    endtask

`ifdef WAM_DEATHMATCH_EN
    task automatic test_deathmatch();
        bit ok;
        do_reset();
        deathmatch = 1'b1;
        do_start(8'hA5, 1, 5, 5);
        deathmatch = 1'b0;
        wait_lit(ok);
        hit_valid = 1'b1;
        hit_idx   = 4'd1;
        tick();
        hit_valid = 1'b0;
        wait_lit(ok);
        hit_valid = 1'b1;
        hit_idx   = 4'd0;
        tick();
        hit_valid = 1'b0;
        checks++;
        if (!ok || misses !== 6'd1 || round_cnt !== 6'd2 || score !== 6'd1 || miss_pulse !== 1'b1 ||
            game_over !== 1'b1) begin
            errors++;
            $display("FAIL deathmatch_end: misses=%0d round=%0d score=%0d mp=%b go=%b, required 1 2 1 1 1",
                     misses, round_cnt, score, miss_pulse, game_over);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_timeout_rounds();
        test_hits();
        test_hit_on_timeout_and_wrong();
        test_restart();
        test_zero_points_and_seed0();
        test_long_run();
`ifdef WAM_DEATHMATCH_EN
        test_deathmatch();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wam_round_controller.md
Name: wam_round_controller

Overview:
Sequences one whack-a-mole game: schedules mole (light) rounds, times the gap and on-windows, and judges keypad hits against the lit mole. It keeps score, miss and round counts and signals game end. Sits between the top-level game FSM/difficulty decode and the LED/keypad controllers, replacing free-running light flicking with a scored, round-limited schedule.

Parameters:
NUM_MOLES, 9, number of lights/keys; one-hot light width.
TIMER_W, 28, width of time_on/time_between and the internal timer.
CNT_W, 6, width of total_points, score, misses and round counter.

Ports:
clk  input  1  system clock (CLOCK_50 at top).
reset  input  1  synchronous, active-high reset.
start  input  1  single-cycle pulse; starts a game, or restarts one in progress.
seed  input  8  LFSR seed; loaded on any cycle where start=1.
time_between  input  TIMER_W  gap terminal count; gap lasts time_between+1 cycles.
time_on  input  TIMER_W  on-window terminal count; window lasts up to time_on+1 cycles.
total_points  input  CNT_W  number of rounds per game.
hit_valid  input  1  single-cycle keypad press strobe.
hit_idx  input  4  pressed key index, 0..NUM_MOLES-1.
lights  output  NUM_MOLES  one-hot lit mole; all zero outside ON.
score  output  CNT_W  correct hits this game.
misses  output  CNT_W  timed-out rounds this game.
round_cnt  output  CNT_W  completed rounds.
hit_pulse  output  1  one-cycle pulse on a correct hit.
miss_pulse  output  1  one-cycle pulse on a timeout.
game_over  output  1  high in DONE.

Behaviour:
- Reset: state IDLE; all outputs 0; timer 0; LFSR 8'hA5; prev mole index 0.
- States: IDLE, GAP, ON, DONE. All outputs registered.
- start (any state): latch time_between, time_on, total_points; clear score/misses/round_cnt/timer; load LFSR with seed (8'hA5 if seed==0). Next state GAP, or DONE if total_points==0. Inputs are not resampled until the next start.
- GAP: timer counts up from 0; at timer==time_between go ON next cycle, timer=0. The mole index is computed on the same transition.
- Mole pick: 8-bit Galois LFSR (x^8+x^6+x^5+x^4+1) steps once per transition GAP->ON. idx = lfsr[3:0], minus NUM_MOLES if >= NUM_MOLES. If idx equals the previous mole, use (idx+1) mod NUM_MOLES.
- ON: lights = one-hot(idx) from the first ON cycle. The timer counts.
  - hit_valid with hit_idx==idx: score+1, hit_pulse; round ends.
  - timer==time_on with no correct hit that cycle: misses+1, miss_pulse; round ends. A hit in the same cycle as the timeout wins.
  - Wrong-index hits are ignored.
- Round end: round_cnt+1 and lights cleared next cycle. Go to DONE if the new round_cnt==total_points, else GAP (timer=0).
- hit_valid outside ON is ignored.
- DONE: game_over=1; counters hold; only start or reset leaves.
- Counters saturate at all-ones (no wrap).
- Reset has priority over start.

Optional Feature:
WAM_DEATHMATCH_EN
- Defined: adds input deathmatch (1 bit, latched on start). When latched high, a timeout or a wrong-index hit in ON ends the game. misses+1 and miss_pulse still occur; next state is DONE regardless of round_cnt.
- Undefined: no deathmatch port. Wrong hits are ignored and games always run total_points rounds.

Test Plan:
- reset, then idle 10 cycles -> lights=0, score=misses=round_cnt=0, game_over=0, state IDLE.
- start with time_between=3, time_on=5, total_points=2, no hits -> lights nonzero 4 cycles after start for exactly 6 cycles. miss_pulse at each timeout, misses=2, round_cnt=2, game_over=1.
- Same config, correct hit on 2nd ON cycle of each round -> hit_pulse each round, lights clear next cycle, score=2, misses=0, game_over=1.
- Correct hit exactly on the timeout cycle -> score+1, no miss_pulse. Wrong-index hit mid-ON -> no count change, lights stay on.
- start pulse mid-ON of round 1 of 3 -> counters cleared, lights=0 next cycle, GAP restarts. total_points=0 start -> game_over=1 next cycle. seed=0 -> LFSR uses 8'hA5. Over 50 rounds: no consecutive repeat, every idx<9.
- WAM_DEATHMATCH_EN, deathmatch=1, total_points=5, wrong hit in round 2 -> misses=1, round_cnt=2, game_over=1.
